// File: rtl/const_decode.sv
// const_decode: decode/issue stage for the constant ALU (LOADLIT, LCL, LCH).
// One-entry output register behind a valid/ready handshake, with a
// per-register pending-write scoreboard that stalls constant instructions
// whose destination still has an outstanding write.
module const_decode #(
  parameter int unsigned bits_palavra = 16,
  parameter int unsigned n_regs       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [bits_palavra-1:0] instr,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [bits_palavra-1:0] constante,
  output logic [1:0]              formato,
  output logic                    R,
  output logic [3:0]              rd,
  input  logic                    wb_valid,
  input  logic [3:0]              wb_addr,
  input  logic                    flush,
  output logic [15:0]             stall_count
);

  localparam int unsigned byte_w = 8;
  localparam logic [15:0] stall_max = 16'hFFFF;

  localparam logic [3:0] op_loadlit = 4'h1;
  localparam logic [3:0] op_lcl     = 4'h2;
  localparam logic [3:0] op_lch     = 4'h3;

  logic [3:0]              opcode;
  logic [3:0]              dest;
  logic [byte_w-1:0]       imm;

  logic [bits_palavra-1:0] dec_const;
  logic [1:0]              dec_formato;
  logic                    dec_r;
  logic                    is_const;

  logic [n_regs-1:0]       pend;
  logic [n_regs-1:0]       pend_next;
  logic [n_regs-1:0]       wb_mask;
  logic [n_regs-1:0]       flush_mask;
  logic [n_regs-1:0]       set_mask;
  logic [n_regs-1:0]       eff;

  logic                    held_const;
  logic                    hazard;
  logic                    accept;

  assign opcode = instr[15:12];
  assign dest   = instr[11:8];
  assign imm    = instr[7:0];

  // Decode the opcode and position the immediate for the ALU
  always_comb begin
    dec_const   = '0;
    dec_formato = 2'b00;
    dec_r       = 1'b0;
    is_const    = 1'b0;
    case (opcode)
      op_loadlit: begin
        dec_const   = {{byte_w{imm[byte_w-1]}}, imm};
        dec_formato = 2'b01;
        is_const    = 1'b1;
      end
      op_lcl: begin
        dec_const   = {{byte_w{1'b0}}, imm};
        dec_formato = 2'b11;
        is_const    = 1'b1;
      end
      op_lch: begin
        dec_const   = {imm, {byte_w{1'b0}}};
        dec_formato = 2'b11;
        dec_r       = 1'b1;
        is_const    = 1'b1;
      end
      default: begin
        dec_const   = '0;
        dec_formato = 2'b00;
        dec_r       = 1'b0;
        is_const    = 1'b0;
      end
    endcase
  end

  // Hazard detection with same-cycle writeback bypass, handshake and scoreboard update
  always_comb begin
    wb_mask    = wb_valid ? (n_regs'(1) << wb_addr) : '0;
    eff        = pend & ~wb_mask;
    hazard     = in_valid && is_const && eff[dest];
    in_ready   = !flush && !hazard && (!out_valid || out_ready);
    accept     = in_valid && in_ready;
    flush_mask = (flush && out_valid && held_const) ? (n_regs'(1) << rd) : '0;
    set_mask   = (accept && is_const) ? (n_regs'(1) << dest) : '0;
    // set is applied last so it wins over a same-cycle clear
    pend_next  = (pend & ~wb_mask & ~flush_mask) | set_mask;
  end

  // Output register, scoreboard and stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      constante   <= '0;
      formato     <= 2'b00;
      R           <= 1'b0;
      rd          <= 4'h0;
      held_const  <= 1'b0;
      pend        <= '0;
      stall_count <= 16'h0000;
    end else begin
      pend <= pend_next;
      if (flush) begin
        out_valid  <= 1'b0;
        held_const <= 1'b0;
      end else if (accept) begin
        out_valid  <= 1'b1;
        constante  <= dec_const;
        formato    <= dec_formato;
        R          <= dec_r;
        rd         <= dest;
        held_const <= is_const;
      end else if (out_valid && out_ready) begin
        out_valid  <= 1'b0;
        held_const <= 1'b0;
      end
      if (hazard && !flush && (stall_count != stall_max)) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/const_decode.md
# const_decode

Decode/issue stage directly upstream of the constant ALU. It accepts 16-bit instruction words over a valid/ready handshake and decodes the load-constant instructions LOADLIT, LCL and LCH. It places the immediate in its final byte position and drives the ALU's `constante`, `formato` and `R` controls plus the destination register from a one-entry output register. A per-register pending-write scoreboard stalls any constant instruction whose destination still has an outstanding write. This keeps LCL/LCH from merging with a stale `dado`.

## Interface
- `bits_palavra`, 16, data/instruction word width (only 16 supported)
- `n_regs`, 16, register count; register address width is 4 bits

- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `instr`  in  16  instruction word
- `in_valid`  in  1  `instr` valid
- `in_ready`  out  1  stage accepts `instr` this cycle
- `out_valid`  out  1  decoded instruction held in the output register
- `out_ready`  in  1  downstream consumes the held instruction
- `constante`  out  16  positioned immediate for the constant ALU
- `formato`  out  2  ALU operation format
- `R`  out  1  byte select for `formato` 11: 0 = LCL, 1 = LCH
- `rd`  out  4  destination register; also the register-file read address for `dado`
- `wb_valid`  in  1  a register write completes this cycle
- `wb_addr`  in  4  register written
- `flush`  in  1  discard the held instruction
- `stall_count`  out  16  saturating count of hazard stall cycles

## Operation
- Opcode is `instr[15:12]`, destination is `instr[11:8]`, immediate is `imm = instr[7:0]`.
- 4'h1 LOADLIT: `constante = {{8{imm[7]}}, imm}`, `formato = 01`, `R = 0`.
- 4'h2 LCL: `constante = {8'h00, imm}`, `formato = 11`, `R = 0`.
- 4'h3 LCH: `constante = {imm, 8'h00}`, `formato = 11`, `R = 1`.
- Any other opcode: `constante = 0`, `formato = 00`, `R = 0`, `rd = instr[11:8]`.
  - Passed through with no scoreboard effect and never stalled.
- Constant instruction: opcode 1, 2 or 3.
- Scoreboard `pend[n_regs-1:0]`:
  - The bit for `rd` is set when a constant instruction is accepted.
  - A bit is cleared when `wb_valid` arrives with `wb_addr` pointing at it.
  - Set and clear of the same bit in the same cycle: set wins.
- Effective pending: `eff = pend & ~(wb_valid ? onehot(wb_addr) : 0)`. A same-cycle writeback is therefore bypassed.
- Hazard: `in_valid`, the instruction is a constant instruction, and `eff[instr[11:8]]` is set.
- `in_ready = !flush && !hazard && (!out_valid || out_ready)`. This is combinational.
- Accept occurs when `in_valid && in_ready`. The decoded fields load into the output register and `out_valid` goes to 1.
- Consume without accept (`out_valid && out_ready` and no new accept): `out_valid` goes to 0.
- While `out_valid && !out_ready`, all outputs are held stable.
- Flush takes priority over everything else.
  - Next cycle `out_valid = 0`.
  - If the held instruction was a constant instruction, its `pend[rd]` bit is cleared.
  - Scoreboard bits of already-consumed instructions are kept.
  - No accept happens during the flush cycle.
- `stall_count` increments in each cycle where `in_valid && hazard && !flush`. It saturates at 16'hFFFF.

## Timing
- Reset values:
  - `out_valid = 0`, `constante = 0`, `formato = 00`, `R = 0`, `rd = 0`.
  - `pend = 0`, `stall_count = 0`.
- First cycle after reset: `in_ready = 1`.
- Latency: accept in cycle N gives `out_valid` and valid fields in N+1.
- Throughput: 1 instruction/cycle when `out_ready` is held at 1 and there are no hazards.
- A `wb_valid` in cycle N unblocks a stalled instruction in the same cycle N.
- Reset mid-operation drops the held instruction and clears all scoreboard state. Any writebacks still in flight are ignored.
- An illegal input such as `wb_valid` to a register that is not pending is harmless: the bit stays 0.

## Test plan
- Reset, then `instr = 16'h23AB`, `in_valid = 1`, `out_ready = 1`:
  - next cycle `out_valid = 1`, `constante = 16'h00AB`, `formato = 11`, `R = 0`, `rd = 3`.
  - `pend[3] = 1`.
- LCH `16'h3312` issued while `pend[3] = 1`:
  - `in_ready = 0`; `stall_count` goes 0→1→2 over two cycles.
  - Pulse `wb_valid`, `wb_addr = 3`: accepted in the same cycle.
  - Next cycle `constante = 16'h1200`, `R = 1`; `pend[3]` stays 1.
- LOADLIT `16'h1580`:
  - `constante = 16'hFF80`, `formato = 01`, `rd = 5`.
  - LOADLIT `16'h157F` to a free register gives `constante = 16'h007F`.
- `out_ready = 0` for 3 cycles with an instruction held:
  - outputs constant, `in_ready = 0`.
  - Raising `out_ready` with a new `instr` present gives back-to-back transfer with no bubble.
- Held LCL r5, not yet consumed, then `flush = 1`:
  - next cycle `out_valid = 0`, `pend[5] = 0`.
  - A new LCL to r5 is accepted without stall.
- Non-constant `16'h7A12`:
  - `formato = 00`, `constante = 0`, `rd = 10`; scoreboard unchanged.
  - Never stalls even when `pend[10] = 1`.
